// File: rtl/jump_hazard_ctrl.sv
// Control-flow hazard sequencer for jumps and branches resolved in ID.
// Drives the forwarding selects for the ID compare and jump-register datapath.
// Holds IF/ID while a load producer is still in flight.
// Then issues a one-cycle PC redirect and squashes the wrong-path fetch.
//
// state    | meaning
// ST_IDLE  | evaluate hazards; either detect a load hazard (stall) or resolve the cf
// ST_WAIT2 | second stall cycle of an EX-stage load hazard (load now in MEM)
//
// An EX-stage load costs two stall cycles: the detect cycle plus ST_WAIT2.
// A MEM-stage load costs one stall cycle: the detect cycle only.
// In both cases the FSM is back in ST_IDLE when the load reaches WB.
// At that point the register file supplies the value (write first half, read second half).
module jump_hazard_ctrl #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             jump_d,
    input  logic             jr_d,
    input  logic             branch_d,
    input  logic             branch_taken,
    input  logic [4:0]       rs_d,
    input  logic [4:0]       rt_d,
    input  logic             reg_write_e,
    input  logic             mem_to_reg_e,
    input  logic [4:0]       write_reg_e,
    input  logic             reg_write_m,
    input  logic             mem_to_reg_m,
    input  logic [4:0]       write_reg_m,
    input  logic             stall_ext,
    output logic [1:0]       fw_rd1,
    output logic [1:0]       fw_rd2,
    output logic             stall_f,
    output logic             stall_d,
    output logic             flush_e,
    output logic             flush_d,
    output logic             pc_sel,
    output logic [CNT_W-1:0] jump_cnt,
    output logic [CNT_W-1:0] stall_cnt
);

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_WAIT2 = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] jump_cnt_q, jump_cnt_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

    logic cf, need_rs, need_rt, redirect;
    logic hit_e_rs, hit_m_rs, hit_e_rt, hit_m_rt;
    logic ld_e_any, ld_m_any;
    logic stall, jump_inc, stall_inc;

    // Per-source hit detection; $0 never hazards
    always_comb begin
        hit_e_rs = reg_write_e && (rs_d != 5'd0) && (write_reg_e == rs_d);
        hit_m_rs = reg_write_m && (rs_d != 5'd0) && (write_reg_m == rs_d);
        hit_e_rt = reg_write_e && (rt_d != 5'd0) && (write_reg_e == rt_d);
        hit_m_rt = reg_write_m && (rt_d != 5'd0) && (write_reg_m == rt_d);
    end

    // Forward selects: EX alu result beats MEM alu result; loads never forward here
    always_comb begin
        fw_rd1 = 2'b00;
        fw_rd2 = 2'b00;
        if (hit_e_rs && !mem_to_reg_e)      fw_rd1 = 2'b10;
        else if (hit_m_rs && !mem_to_reg_m) fw_rd1 = 2'b01;
        if (hit_e_rt && !mem_to_reg_e)      fw_rd2 = 2'b10;
        else if (hit_m_rt && !mem_to_reg_m) fw_rd2 = 2'b01;
    end

    // Classify the instruction in ID and any load hazard on the sources it reads
    always_comb begin
        cf       = jump_d || jr_d || branch_d;
        need_rs  = jr_d || branch_d;
        need_rt  = branch_d;
        redirect = jump_d || jr_d || (branch_d && branch_taken);
        ld_e_any = mem_to_reg_e && ((need_rs && hit_e_rs) || (need_rt && hit_e_rt));
        ld_m_any = mem_to_reg_m && ((need_rs && hit_m_rs) || (need_rt && hit_m_rt));
    end

    // Next-state, stall/redirect outputs and counter enables
    always_comb begin
        state_d   = state_q;
        stall     = 1'b0;
        pc_sel    = 1'b0;
        flush_d   = 1'b0;
        jump_inc  = 1'b0;
        stall_inc = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (cf && (ld_e_any || ld_m_any)) begin
                    stall = 1'b1;
                    if (!stall_ext) begin
                        stall_inc = 1'b1;
                        if (ld_e_any) state_d = ST_WAIT2;
                    end
                end else if (redirect && !stall_ext) begin
                    pc_sel   = 1'b1;
                    flush_d  = 1'b1;
                    jump_inc = 1'b1;
                end
            end
            ST_WAIT2: begin
                stall = 1'b1;
                if (!stall_ext) begin
                    stall_inc = 1'b1;
                    state_d   = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        // Reset acts immediately on the outputs, not only at the next edge
        if (reset) begin
            stall     = 1'b0;
            pc_sel    = 1'b0;
            flush_d   = 1'b0;
            jump_inc  = 1'b0;
            stall_inc = 1'b0;
        end
    end

    // Saturating counter next values
    always_comb begin
        jump_cnt_d  = jump_cnt_q;
        stall_cnt_d = stall_cnt_q;
        if (jump_inc && (jump_cnt_q != '1))   jump_cnt_d  = jump_cnt_q + 1'b1;
        if (stall_inc && (stall_cnt_q != '1)) stall_cnt_d = stall_cnt_q + 1'b1;
    end

    // State and counter registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            jump_cnt_q  <= '0;
            stall_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            jump_cnt_q  <= jump_cnt_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign stall_f   = stall;
    assign stall_d   = stall;
    assign flush_e   = stall;
    assign jump_cnt  = jump_cnt_q;
    assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_jump_hazard_ctrl.sv
// Bench for jump_hazard_ctrl.
// It runs directed table vectors, then hand sequences for reset and saturation,
// then a random phase checked against a cycle-level reference model.
module tb_jump_hazard_ctrl;

    localparam int CNT_W = 4;
    localparam int CMAX  = (1 << CNT_W) - 1;

    logic clk = 1'b0;
    logic reset;
    logic jump_d, jr_d, branch_d, branch_taken;
    logic [4:0] rs_d, rt_d, write_reg_e, write_reg_m;
    logic reg_write_e, mem_to_reg_e, reg_write_m, mem_to_reg_m, stall_ext;
    logic [1:0] fw_rd1, fw_rd2;
    logic stall_f, stall_d, flush_e, flush_d, pc_sel;
    logic [CNT_W-1:0] jump_cnt, stall_cnt;

    int n_vec  = 0;
    int n_fail = 0;

    jump_hazard_ctrl #(.CNT_W(CNT_W)) dut (
        .clk(clk), .reset(reset), .jump_d(jump_d), .jr_d(jr_d), .branch_d(branch_d),
        .branch_taken(branch_taken), .rs_d(rs_d), .rt_d(rt_d),
        .reg_write_e(reg_write_e), .mem_to_reg_e(mem_to_reg_e), .write_reg_e(write_reg_e),
        .reg_write_m(reg_write_m), .mem_to_reg_m(mem_to_reg_m), .write_reg_m(write_reg_m),
        .stall_ext(stall_ext), .fw_rd1(fw_rd1), .fw_rd2(fw_rd2), .stall_f(stall_f),
        .stall_d(stall_d), .flush_e(flush_e), .flush_d(flush_d), .pc_sel(pc_sel),
        .jump_cnt(jump_cnt), .stall_cnt(stall_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       j, jr, br, tk;
        logic [4:0] rs, rt;
        logic       rwe, lde;
        logic [4:0] wre;
        logic       rwm, ldm;
        logic [4:0] wrm;
        logic       ext;
        logic [1:0] e_fw1, e_fw2;
        logic       e_stall, e_pc;
        int         e_j, e_s;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(logic j, logic jr, logic br, logic tk, int rs, int rt,
                                logic rwe, logic lde, int wre, logic rwm, logic ldm, int wrm,
                                logic ext, logic [1:0] f1, logic [1:0] f2, logic st,
                                logic pc, int ej, int es);
        vec_t v;
        v.j = j; v.jr = jr; v.br = br; v.tk = tk; v.rs = rs[4:0]; v.rt = rt[4:0];
        v.rwe = rwe; v.lde = lde; v.wre = wre[4:0]; v.rwm = rwm; v.ldm = ldm; v.wrm = wrm[4:0];
        v.ext = ext; v.e_fw1 = f1; v.e_fw2 = f2; v.e_stall = st; v.e_pc = pc;
        v.e_j = ej; v.e_s = es;
        return v;
    endfunction

    task automatic drive(input vec_t v);
        jump_d = v.j; jr_d = v.jr; branch_d = v.br; branch_taken = v.tk;
        rs_d = v.rs; rt_d = v.rt;
        reg_write_e = v.rwe; mem_to_reg_e = v.lde; write_reg_e = v.wre;
        reg_write_m = v.rwm; mem_to_reg_m = v.ldm; write_reg_m = v.wrm;
        stall_ext = v.ext;
    endtask

    task automatic check(input string name, input logic [1:0] f1, input logic [1:0] f2,
                         input logic st, input logic pc, input int ej, input int es);
        logic ok;
        n_vec++;
        ok = (fw_rd1 === f1) && (fw_rd2 === f2) && (stall_f === st) && (stall_d === st) &&
             (flush_e === st) && (pc_sel === pc) && (flush_d === pc) &&
             (jump_cnt === ej[CNT_W-1:0]) && (stall_cnt === es[CNT_W-1:0]);
        if (!ok) begin
            n_fail++;
            $display("FAIL %s: got fw=%b/%b stall=%b%b%b pc_sel=%b flush_d=%b jcnt=%0d scnt=%0d; want fw=%b/%b stall=%b pc_sel=%b jcnt=%0d scnt=%0d",
                     name, fw_rd1, fw_rd2, stall_f, stall_d, flush_e, pc_sel, flush_d,
                     jump_cnt, stall_cnt, f1, f2, st, pc, ej, es);
        end
    endtask

    // Reference model: count of remaining stall cycles plus two saturating counts
    int m_left, m_j, m_s;

    function automatic logic [1:0] ref_fw(input logic [4:0] src);
        if (src != 0 && reg_write_e && write_reg_e == src && !mem_to_reg_e) return 2'b10;
        if (src != 0 && reg_write_m && write_reg_m == src && !mem_to_reg_m) return 2'b01;
        return 2'b00;
    endfunction

    function automatic logic load_in(input logic [4:0] src, input logic rw, input logic ld,
                                     input logic [4:0] dst);
        return (src != 0) && rw && ld && (dst == src);
    endfunction

    task automatic model_step(input string name);
        logic cf, nrs, nrt, lde_any, ldm_any, det, st, pc;
        cf  = jump_d | jr_d | branch_d;
        nrs = jr_d | branch_d;
        nrt = branch_d;
        lde_any = (nrs && load_in(rs_d, reg_write_e, mem_to_reg_e, write_reg_e)) ||
                  (nrt && load_in(rt_d, reg_write_e, mem_to_reg_e, write_reg_e));
        ldm_any = (nrs && load_in(rs_d, reg_write_m, mem_to_reg_m, write_reg_m)) ||
                  (nrt && load_in(rt_d, reg_write_m, mem_to_reg_m, write_reg_m));
        det = (m_left == 0) && cf && (lde_any || ldm_any);
        st  = (m_left > 0) || det;
        pc  = !st && !stall_ext && (jump_d || jr_d || (branch_d && branch_taken));
        check(name, ref_fw(rs_d), ref_fw(rt_d), st, pc, m_j, m_s);
        if (!stall_ext) begin
            if (m_left > 0) begin
                m_left--;
                if (m_s < CMAX) m_s++;
            end else if (det) begin
                m_left = lde_any ? 1 : 0;
                if (m_s < CMAX) m_s++;
            end else if (pc) begin
                if (m_j < CMAX) m_j++;
            end
        end
    endtask

    initial begin
        vec_t z;
        z = mk(0,0,0,0, 0,0, 0,0,0, 0,0,0, 0, 2'b00,2'b00,0,0,0,0);
        reset = 1'b1;
        drive(z);

        //          j jr br tk rs rt rwe lde wre rwm ldm wrm ext fw1    fw2    st pc  j  s
        tbl.push_back(mk(0,0,0,0, 0,0, 0,0,0, 0,0,0, 0, 2'b00,2'b00,0,0, 0,0)); // idle
        tbl.push_back(mk(0,1,0,0, 5,0, 1,0,5, 0,0,0, 0, 2'b10,2'b00,0,1, 0,0)); // jr fwd EX
        tbl.push_back(mk(0,0,0,0, 0,0, 0,0,0, 0,0,0, 0, 2'b00,2'b00,0,0, 1,0));
        tbl.push_back(mk(0,1,0,0, 7,0, 1,1,7, 0,0,0, 0, 2'b00,2'b00,1,0, 1,0)); // lw in EX
        tbl.push_back(mk(0,1,0,0, 7,0, 0,0,0, 1,1,7, 0, 2'b00,2'b00,1,0, 1,1)); // wait2
        tbl.push_back(mk(0,1,0,0, 7,0, 0,0,0, 0,0,0, 0, 2'b00,2'b00,0,1, 1,2)); // resolve
        tbl.push_back(mk(0,0,0,0, 0,0, 0,0,0, 0,0,0, 0, 2'b00,2'b00,0,0, 2,2));
        tbl.push_back(mk(0,0,1,0, 3,4, 1,0,3, 1,0,4, 0, 2'b10,2'b01,0,0, 2,2)); // beq not taken
        tbl.push_back(mk(0,0,1,1, 0,0, 1,0,0, 1,0,0, 0, 2'b00,2'b00,0,1, 2,2)); // beq $0,$0
        tbl.push_back(mk(0,0,0,0, 5,0, 1,0,5, 1,0,5, 0, 2'b10,2'b00,0,0, 3,2)); // EX priority
        tbl.push_back(mk(0,1,0,0, 2,0, 0,0,0, 1,1,2, 1, 2'b00,2'b00,1,0, 3,2)); // lw MEM, ext
        tbl.push_back(mk(0,1,0,0, 2,0, 0,0,0, 1,1,2, 1, 2'b00,2'b00,1,0, 3,2));
        tbl.push_back(mk(0,1,0,0, 2,0, 0,0,0, 1,1,2, 1, 2'b00,2'b00,1,0, 3,2));
        tbl.push_back(mk(0,1,0,0, 2,0, 0,0,0, 1,1,2, 0, 2'b00,2'b00,1,0, 3,2));
        tbl.push_back(mk(0,1,0,0, 2,0, 0,0,0, 0,0,0, 0, 2'b00,2'b00,0,1, 3,3)); // redirect
        tbl.push_back(mk(0,1,0,0, 2,0, 0,0,0, 0,0,0, 1, 2'b00,2'b00,0,0, 4,3)); // ext blocks pc
        tbl.push_back(mk(0,0,0,0, 0,0, 0,0,0, 0,0,0, 0, 2'b00,2'b00,0,0, 4,3));

        @(negedge clk);
        check("reset_state", 2'b00, 2'b00, 0, 0, 0, 0);
        @(posedge clk); #1;
        reset = 1'b0;

        for (int i = 0; i < tbl.size(); i++) begin
            drive(tbl[i]);
            @(negedge clk);
            check($sformatf("tbl%0d", i), tbl[i].e_fw1, tbl[i].e_fw2, tbl[i].e_stall,
                  tbl[i].e_pc, tbl[i].e_j, tbl[i].e_s);
            @(posedge clk); #1;
        end

        // Async reset in the middle of an EX-load wait
        drive(mk(0,1,0,0, 7,0, 1,1,7, 0,0,0, 0, 2'b00,2'b00,0,0,0,0));
        @(negedge clk);
        check("ld_detect", 2'b00, 2'b00, 1, 0, 4, 3);
        @(posedge clk); #1;
        drive(mk(0,1,0,0, 7,0, 0,0,0, 1,1,7, 0, 2'b00,2'b00,0,0,0,0));
        #1;
        check("in_wait2", 2'b00, 2'b00, 1, 0, 4, 4);
        reset = 1'b1;
        #1;
        check("async_reset", 2'b00, 2'b00, 0, 0, 0, 0);
        @(posedge clk); #1;
        drive(z);
        reset = 1'b0;

        // Jump counter saturation
        drive(mk(1,0,0,0, 0,0, 0,0,0, 0,0,0, 0, 2'b00,2'b00,0,0,0,0));
        for (int i = 0; i < CMAX + 5; i++) begin
            @(posedge clk); #1;
        end
        drive(z);
        @(negedge clk);
        check("jcnt_sat", 2'b00, 2'b00, 0, 0, CMAX, 0);

        // Random phase from a fresh reset
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        m_left = 0; m_j = 0; m_s = 0;
        for (int i = 0; i < 600; i++) begin
            int k;
            k = $urandom_range(0, 3);
            jump_d = (k == 1); jr_d = (k == 2); branch_d = (k == 3);
            branch_taken = 1'($urandom);
            rs_d = 5'($urandom_range(0, 3)); rt_d = 5'($urandom_range(0, 3));
            reg_write_e = 1'($urandom); mem_to_reg_e = 1'($urandom);
            write_reg_e = 5'($urandom_range(0, 3));
            reg_write_m = 1'($urandom); mem_to_reg_m = 1'($urandom);
            write_reg_m = 5'($urandom_range(0, 3));
            stall_ext = ($urandom_range(0, 7) == 0);
            @(negedge clk);
            model_step($sformatf("rand%0d", i));
            @(posedge clk); #1;
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
